lc3_dmem_responder: RTL and testbench



---
 rtl/lc3_dmem_pkg.sv | 15 +
 rtl/lc3_dmem_array.sv | 23 ++
 rtl/lc3_dmem_responder.sv | 157 +++++++++++++++
 tb/tb_lc3_dmem_responder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/lc3_dmem_pkg.sv
// Shared types and constants for the LC3 data-memory responder.
package lc3_dmem_pkg;

  localparam int unsigned DMEM_DEPTH = 256;
  localparam int unsigned IDX_W      = $clog2(DMEM_DEPTH);
  localparam int unsigned WCNT_W     = 4;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/lc3_dmem_array.sv
// Single-port synchronous RAM with registered read and no reset.
module lc3_dmem_array #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned IW     = 8
) (
  input  logic              clock,
  input  logic              we,
  input  logic [IW-1:0]     idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[idx] <= wdata;
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/lc3_dmem_responder.sv
// LC3 data-memory responder: self-clearing word array with configurable
// wait states, one-cycle ack and alias flag for out-of-range address bits.
module lc3_dmem_responder
  import lc3_dmem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned DEPTH       = DMEM_DEPTH,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              dmem_en,
  input  logic              dmem_rd,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [DATA_W-1:0] dmem_din,
  output logic [DATA_W-1:0] dmem_dout,
  output logic              dmem_ack,
  output logic              dmem_busy,
  output logic              dmem_alias
);

  localparam int unsigned IW = $clog2(DEPTH);

  state_e              state_q, state_d;
  logic [IW-1:0]       clr_q, clr_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic                cap_rd_q, cap_rd_d;
  logic [IW-1:0]       cap_addr_q, cap_addr_d;
  logic [DATA_W-1:0]   cap_din_q, cap_din_d;
  logic                cap_alias_q, cap_alias_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                ack_q, ack_d;
  logic                alias_q, alias_d;
  logic                busy_q, busy_d;

  logic                arr_we_c;
  logic [IW-1:0]       arr_idx_c;
  logic [DATA_W-1:0]   arr_wdata_c;
  logic [DATA_W-1:0]   arr_rdata;
  logic                alias_c;

  assign alias_c = |(dmem_addr >> IW);

  lc3_dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IW     (IW)
  ) u_array (
    .clock (clock),
    .we    (arr_we_c & ~reset),
    .idx   (arr_idx_c),
    .wdata (arr_wdata_c),
    .rdata (arr_rdata)
  );

  // Next-state, capture and RAM port steering; the RAM is addressed one
  // cycle ahead so its registered read lands at the edge entering RESP.
  always_comb begin
    state_d     = state_q;
    clr_d       = clr_q;
    wcnt_d      = wcnt_q;
    cap_rd_d    = cap_rd_q;
    cap_addr_d  = cap_addr_q;
    cap_din_d   = cap_din_q;
    cap_alias_d = cap_alias_q;
    dout_d      = dout_q;
    arr_we_c    = 1'b0;
    arr_idx_c   = cap_addr_q;
    arr_wdata_c = cap_din_q;

    case (state_q)
      CLEAR: begin
        arr_we_c    = 1'b1;
        arr_idx_c   = clr_q;
        arr_wdata_c = '0;
        if (clr_q == IW'(DEPTH - 1)) begin
          state_d = IDLE;
        end else begin
          clr_d = clr_q + 1'b1;
        end
      end
      IDLE: begin
        arr_idx_c   = dmem_addr[IW-1:0];
        arr_wdata_c = dmem_din;
        if (dmem_en) begin
          cap_rd_d    = dmem_rd;
          cap_addr_d  = dmem_addr[IW-1:0];
          cap_din_d   = dmem_din;
          cap_alias_d = alias_c;
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            wcnt_d  = WCNT_W'(WAIT_STATES - 1);
          end else begin
            state_d  = RESP;
            arr_we_c = ~dmem_rd;
          end
        end
      end
      WAIT: begin
        if (wcnt_q == '0) begin
          state_d  = RESP;
          arr_we_c = ~cap_rd_q;
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (cap_rd_q) begin
          dout_d = arr_rdata;
        end
      end
      default: state_d = CLEAR;
    endcase

    ack_d   = (state_d == RESP);
    alias_d = (state_d == RESP) & cap_alias_d;
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= CLEAR;
      clr_q       <= '0;
      wcnt_q      <= '0;
      cap_rd_q    <= 1'b0;
      cap_addr_q  <= '0;
      cap_din_q   <= '0;
      cap_alias_q <= 1'b0;
      dout_q      <= '0;
      ack_q       <= 1'b0;
      alias_q     <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      clr_q       <= clr_d;
      wcnt_q      <= wcnt_d;
      cap_rd_q    <= cap_rd_d;
      cap_addr_q  <= cap_addr_d;
      cap_din_q   <= cap_din_d;
      cap_alias_q <= cap_alias_d;
      dout_q      <= dout_d;
      ack_q       <= ack_d;
      alias_q     <= alias_d;
      busy_q      <= busy_d;
    end
  end

  // During a read RESP the RAM output register already holds the word;
  // dout_q takes it over at RESP exit and holds until the next read.
  assign dmem_dout  = (state_q == RESP && cap_rd_q) ? arr_rdata : dout_q;
  assign dmem_ack   = ack_q;
  assign dmem_alias = alias_q;
  assign dmem_busy  = busy_q;

endmodule

// File: tb/tb_lc3_dmem_responder.sv
// Directed bench: instance 0 uses two wait states, instance 1 uses none.
module tb_lc3_dmem_responder;

  logic        clock;
  logic        reset;
  logic        en       [2];
  logic        rd       [2];
  logic [15:0] addr     [2];
  logic [15:0] din      [2];
  logic [15:0] dout     [2];
  logic        ack      [2];
  logic        busy     [2];
  logic        al       [2];

  int n_chk;
  int n_pass;

  lc3_dmem_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH(256), .WAIT_STATES(2)) u_dut_w2 (
    .clock(clock), .reset(reset), .dmem_en(en[0]), .dmem_rd(rd[0]),
    .dmem_addr(addr[0]), .dmem_din(din[0]), .dmem_dout(dout[0]),
    .dmem_ack(ack[0]), .dmem_busy(busy[0]), .dmem_alias(al[0])
  );

  lc3_dmem_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH(256), .WAIT_STATES(0)) u_dut_w0 (
    .clock(clock), .reset(reset), .dmem_en(en[1]), .dmem_rd(rd[1]),
    .dmem_addr(addr[1]), .dmem_din(din[1]), .dmem_dout(dout[1]),
    .dmem_ack(ack[1]), .dmem_busy(busy[1]), .dmem_alias(al[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Issue one request once the DUT is idle; lat counts cycles from acceptance to ack.
  task automatic req(input int d, input logic r, input logic [15:0] a, input logic [15:0] w,
                     output int lat, output logic [15:0] q, output logic alf);
    int n;
    n = 0;
    @(negedge clock);
    while (busy[d] && n < 400) begin
      @(negedge clock);
      n++;
    end
    en[d] = 1'b1; rd[d] = r; addr[d] = a; din[d] = w;
    @(posedge clock);
    #1;
    en[d] = 1'b0;
    n = 1;
    while (!ack[d] && n < 20) begin
      @(posedge clock);
      #1;
      n++;
    end
    lat = ack[d] ? n : -1;
    q   = dout[d];
    alf = al[d];
  endtask

  // Release reset and count edges until busy falls, tallying any acks.
  task automatic run_clear(output int edges, output int acks);
    edges = 0;
    acks  = 0;
    @(negedge clock);
    reset = 1'b0;
    while (edges < 400) begin
      @(posedge clock);
      #1;
      edges++;
      if (ack[0]) acks++;
      if (!busy[0]) break;
    end
    en[0] = 1'b0;
    en[1] = 1'b0;
  endtask

  initial begin
    int          lat;
    int          edges;
    int          acks;
    logic [15:0] q;
    logic        alf;
    time         t1;
    time         t2;

    n_chk = 0; n_pass = 0;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      en[i] = 1'b0; rd[i] = 1'b1; addr[i] = 16'h00A5; din[i] = 16'h0000;
    end

    // Reset clear with a request held active throughout
    en[0] = 1'b1; en[1] = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", 32'(busy[0]), 32'd1);
    chk("rst_ack", 32'(ack[0]), 32'd0);
    chk("rst_alias", 32'(al[0]), 32'd0);
    chk("rst_dout", 32'(dout[0]), 32'h0);
    run_clear(edges, acks);
    chk("clear_cycles", 32'(edges), 32'd256);
    chk("clear_no_ack", 32'(acks), 32'd0);
    chk("clear_busy_w0", 32'(busy[1]), 32'd0);
    req(0, 1'b1, 16'h00A5, 16'h0, lat, q, alf);
    chk("clear_read_a5", 32'(q), 32'h0000);
    chk("clear_read_lat", 32'(lat), 32'd3);

    // Write/read latency with two wait states
    req(0, 1'b0, 16'h0010, 16'h1234, lat, q, alf);
    chk("wr_lat", 32'(lat), 32'd3);
    chk("wr_alias", 32'(alf), 32'd0);
    chk("wr_dout_held", 32'(q), 32'h0000);
    req(0, 1'b1, 16'h0010, 16'h0, lat, q, alf);
    chk("rd_lat", 32'(lat), 32'd3);
    chk("rd_data", 32'(q), 32'h1234);
    chk("rd_alias", 32'(alf), 32'd0);

    // Zero wait states, back-to-back reads
    req(1, 1'b0, 16'h0001, 16'hBEEF, lat, q, alf);
    chk("w0_wr_lat", 32'(lat), 32'd1);
    req(1, 1'b0, 16'h0002, 16'hCAFE, lat, q, alf);
    req(1, 1'b1, 16'h0001, 16'h0, lat, q, alf);
    t1 = $time;
    chk("w0_rd1_lat", 32'(lat), 32'd1);
    chk("w0_rd1_data", 32'(q), 32'hBEEF);
    req(1, 1'b1, 16'h0002, 16'h0, lat, q, alf);
    t2 = $time;
    chk("w0_rd2_data", 32'(q), 32'hCAFE);
    chk("w0_ack_spacing", 32'(t2 - t1), 32'd20);

    // Aliasing wraps modulo DEPTH
    req(0, 1'b0, 16'h0103, 16'h5555, lat, q, alf);
    chk("alias_wr_flag", 32'(alf), 32'd1);
    chk("alias_wr_dout_held", 32'(q), 32'h1234);
    req(0, 1'b1, 16'h0003, 16'h0, lat, q, alf);
    chk("alias_rd_data", 32'(q), 32'h5555);
    chk("alias_rd_flag", 32'(alf), 32'd0);

    // Request during WAIT is dropped
    req(0, 1'b0, 16'h0004, 16'h0AAA, lat, q, alf);
    @(negedge clock);
    while (busy[0]) @(negedge clock);
    en[0] = 1'b1; rd[0] = 1'b1; addr[0] = 16'h0004; din[0] = 16'h0;
    @(posedge clock);
    #1;
    en[0] = 1'b0;
    @(negedge clock);
    en[0] = 1'b1; rd[0] = 1'b0; addr[0] = 16'h0004; din[0] = 16'hFFFF;
    @(posedge clock);
    #1;
    en[0] = 1'b0;
    acks = 0;
    q = 16'hDEAD;
    for (int i = 0; i < 8; i++) begin
      if (ack[0]) begin
        acks++;
        q = dout[0];
      end
      @(posedge clock);
      #1;
    end
    chk("drop_single_ack", 32'(acks), 32'd1);
    chk("drop_rd_data", 32'(q), 32'h0AAA);
    req(0, 1'b1, 16'h0004, 16'h0, lat, q, alf);
    chk("drop_reread", 32'(q), 32'h0AAA);

    // Reset while a write sits in WAIT
    @(negedge clock);
    while (busy[0]) @(negedge clock);
    en[0] = 1'b1; rd[0] = 1'b0; addr[0] = 16'h0020; din[0] = 16'h7777;
    @(posedge clock);
    #1;
    en[0] = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("midrst_ack", 32'(ack[0]), 32'd0);
    chk("midrst_busy", 32'(busy[0]), 32'd1);
    chk("midrst_dout", 32'(dout[0]), 32'h0000);
    @(posedge clock);
    run_clear(edges, acks);
    chk("midrst_clear_cycles", 32'(edges), 32'd256);
    chk("midrst_no_ack", 32'(acks), 32'd0);
    req(0, 1'b1, 16'h0020, 16'h0, lat, q, alf);
    chk("midrst_read", 32'(q), 32'h0000);
    chk("midrst_read_lat", 32'(lat), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
